// File: rtl/prach_pkg.sv
// Shared types for the PRACH CP-removal block.
package prach_pkg;

    // IDLE: waiting for start; SKIP: dropping CP words; PASS: forwarding sequence words.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SKIP = 2'd1,
        PASS = 2'd2
    } cp_state_t;

endpackage

// File: rtl/prach_out_reg.sv
// One-entry valid/ready output register carrying a data word and its last flag.
// The upstream side may load whenever in_ready_o is high (~valid | ready).
module prach_out_reg #(
    parameter int WIDTH = 144
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             last_i,
    input  logic             ready_i,
    output logic             in_ready_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic             last_o
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             last_q, last_d;

    // Load takes priority; otherwise an accepted word empties the register.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        last_d  = last_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
            last_d  = last_i;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    // Register state; data and last are held while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    assign in_ready_o = ~valid_q | ready_i;
    assign valid_o    = valid_q;
    assign data_o     = data_q;
    assign last_o     = last_q;

endmodule

// File: rtl/prach_cp_remove.sv
// Reads the show-ahead CP FIFO, drops the cyclic-prefix words of each symbol
// and forwards the sequence words through a single output register.
//
// state | meaning
// IDLE  | no symbol in progress, FIFO words are held
// SKIP  | consuming and discarding cp_cnt words
// PASS  | forwarding seq_cnt words to the output register
module prach_cp_remove
    import prach_pkg::*;
#(
    parameter int WIDTH = 144,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] cfg_cp_len,
    input  logic [CNT_W-1:0] cfg_seq_len,
    input  logic             s_valid,
    input  logic [WIDTH-1:0] s_data,
    output logic             s_ready,
    output logic             m_valid,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last,
    input  logic             m_ready,
    output logic             busy,
    output logic             done,
    output logic             err_start
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    cp_state_t        state_q, state_d;
    logic [CNT_W-1:0] cp_cnt_q, cp_cnt_d;
    logic [CNT_W-1:0] seq_cnt_q, seq_cnt_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             load;
    logic             load_last;
    logic             out_in_ready;

    // Next-state, counter updates and FIFO handshake for the symbol sequencer.
    always_comb begin
        state_d   = state_q;
        cp_cnt_d  = cp_cnt_q;
        seq_cnt_d = seq_cnt_q;
        s_ready   = 1'b0;
        load      = 1'b0;
        load_last = (seq_cnt_q == CNT_ONE);
        err_d     = 1'b0;
        // Completion of a forwarded symbol is seen when its last word leaves.
        done_d    = m_valid & m_ready & m_last;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    cp_cnt_d  = cfg_cp_len;
                    seq_cnt_d = cfg_seq_len;
                    if (cfg_cp_len != '0) begin
                        state_d = SKIP;
                    end else if (cfg_seq_len != '0) begin
                        state_d = PASS;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            SKIP: begin
                s_ready = 1'b1;
                err_d   = start;
                if (s_valid) begin
                    cp_cnt_d = cp_cnt_q - CNT_ONE;
                    if (cp_cnt_q == CNT_ONE) begin
                        if (seq_cnt_q == '0) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = PASS;
                        end
                    end
                end
            end
            PASS: begin
                s_ready = out_in_ready;
                err_d   = start;
                if (s_valid && out_in_ready) begin
                    load      = 1'b1;
                    seq_cnt_d = seq_cnt_q - CNT_ONE;
                    if (seq_cnt_q == CNT_ONE) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counters and the registered status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cp_cnt_q  <= '0;
            seq_cnt_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cp_cnt_q  <= cp_cnt_d;
            seq_cnt_q <= seq_cnt_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    prach_out_reg #(
        .WIDTH(WIDTH)
    ) u_out_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (load),
        .data_i     (s_data),
        .last_i     (load_last),
        .ready_i    (m_ready),
        .in_ready_o (out_in_ready),
        .valid_o    (m_valid),
        .data_o     (m_data),
        .last_o     (m_last)
    );

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign err_start = err_q;

endmodule
